// File: rtl/bnn_loader_pkg.sv
// Shared types and constants for the BNN parameter loader.
package bnn_loader_pkg;

  typedef enum logic [2:0] {
    R_IMG    = 3'd0,
    R_BNN1_W = 3'd1,
    R_BNN2_W = 3'd2,
    R_MLP1_W = 3'd3,
    R_MLP2_W = 3'd4,
    R_BNN1_T = 3'd5,
    R_BNN2_T = 3'd6,
    R_MLP1_T = 3'd7
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam logic [7:0] HDR_REGION_LIM = 8'h08;
  localparam logic [7:0] HDR_CLEAR      = 8'h0F;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/bnn_region_shreg.sv
// W-bit MSB-first byte shift register; the first byte's surplus high bits fall off the top.
module bnn_region_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [7:0]   data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (en_i) q_q <= {q_q[W-9:0], data_i};
  end

  assign q_o = q_q;

endmodule

// File: rtl/bnn_param_loader.sv
// Byte-stream loader for the BNN operand buses; captures the network class once all regions are loaded.
module bnn_param_loader
  import bnn_loader_pkg::*;
#(
  parameter int IMG_BITS      = 900,
  parameter int BNN1_W_BITS   = 72,
  parameter int BNN2_W_BITS   = 1152,
  parameter int MLP1_W_BITS   = 18432,
  parameter int MLP2_W_BITS   = 320,
  parameter int BNN1_T_BITS   = 32,
  parameter int BNN2_T_BITS   = 112,
  parameter int MLP1_T_BITS   = 320,
  parameter int NUM_CLASS     = 10,
  parameter int SETTLE_CYCLES = 4,
  localparam int CW = $clog2(NUM_CLASS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IMG_BITS-1:0]    img,
  output logic [BNN1_W_BITS-1:0] bnn1_weights,
  output logic [BNN2_W_BITS-1:0] bnn2_weights,
  output logic [MLP1_W_BITS-1:0] mlp1_weights,
  output logic [MLP2_W_BITS-1:0] mlp2_weights,
  output logic [BNN1_T_BITS-1:0] bnn1_threshold,
  output logic [BNN2_T_BITS-1:0] bnn2_threshold,
  output logic [MLP1_T_BITS-1:0] mlp1_threshold,
  output logic [7:0]             loaded,
  input  logic [CW-1:0]          net_class,
  output logic [CW-1:0]          result_class,
  output logic                   result_valid,
  output logic                   err
);

  localparam int BCW = $clog2(nbytes(MLP1_W_BITS));
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  state_e         state_q, state_d;
  region_e        id_q, id_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [7:0]     loaded_q, loaded_d;
  logic [CW-1:0]  rclass_q, rclass_d;
  logic           rvalid_q, rvalid_d;
  logic           err_q, err_d;
  logic [7:0]     sh_en;

  function automatic logic [BCW-1:0] nb_m1(input logic [2:0] id);
    case (id)
      3'd0:    return BCW'(nbytes(IMG_BITS) - 1);
      3'd1:    return BCW'(nbytes(BNN1_W_BITS) - 1);
      3'd2:    return BCW'(nbytes(BNN2_W_BITS) - 1);
      3'd3:    return BCW'(nbytes(MLP1_W_BITS) - 1);
      3'd4:    return BCW'(nbytes(MLP2_W_BITS) - 1);
      3'd5:    return BCW'(nbytes(BNN1_T_BITS) - 1);
      3'd6:    return BCW'(nbytes(BNN2_T_BITS) - 1);
      default: return BCW'(nbytes(MLP1_T_BITS) - 1);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    bcnt_d   = bcnt_q;
    scnt_d   = scnt_q;
    loaded_d = loaded_q;
    rclass_d = rclass_q;
    rvalid_d = rvalid_q;
    err_d    = 1'b0;
    in_ready = 1'b1;
    sh_en    = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          // Any header seen while a result is held retires that result.
          if (state_q == S_DONE) begin
            rvalid_d = 1'b0;
            state_d  = S_IDLE;
          end
          if (in_data < HDR_REGION_LIM) begin
            id_d    = region_e'(in_data[2:0]);
            bcnt_d  = nb_m1(in_data[2:0]);
            state_d = S_LOAD;
          end else if (in_data == HDR_CLEAR) begin
            loaded_d = '0;
            rvalid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          sh_en[id_q] = 1'b1;
          if (bcnt_q == '0) begin
            loaded_d[id_q] = 1'b1;
            if (&loaded_d) begin
              state_d = S_SETTLE;
              scnt_d  = SCW'(SETTLE_CYCLES - 1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
      end
      default: begin
        in_ready = 1'b0;
        if (scnt_q == '0) begin
          rclass_d = net_class;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_q     <= R_IMG;
      bcnt_q   <= '0;
      scnt_q   <= '0;
      loaded_q <= '0;
      rclass_q <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      bcnt_q   <= bcnt_d;
      scnt_q   <= scnt_d;
      loaded_q <= loaded_d;
      rclass_q <= rclass_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign loaded       = loaded_q;
  assign result_class = rclass_q;
  assign result_valid = rvalid_q;
  assign err          = err_q;

  bnn_region_shreg #(.W(IMG_BITS)) u_img (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[0]), .data_i(in_data), .q_o(img));
  bnn_region_shreg #(.W(BNN1_W_BITS)) u_bnn1_w (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[1]), .data_i(in_data), .q_o(bnn1_weights));
  bnn_region_shreg #(.W(BNN2_W_BITS)) u_bnn2_w (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[2]), .data_i(in_data), .q_o(bnn2_weights));
  bnn_region_shreg #(.W(MLP1_W_BITS)) u_mlp1_w (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[3]), .data_i(in_data), .q_o(mlp1_weights));
  bnn_region_shreg #(.W(MLP2_W_BITS)) u_mlp2_w (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[4]), .data_i(in_data), .q_o(mlp2_weights));
  bnn_region_shreg #(.W(BNN1_T_BITS)) u_bnn1_t (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[5]), .data_i(in_data), .q_o(bnn1_threshold));
  bnn_region_shreg #(.W(BNN2_T_BITS)) u_bnn2_t (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[6]), .data_i(in_data), .q_o(bnn2_threshold));
  bnn_region_shreg #(.W(MLP1_T_BITS)) u_mlp1_t (
    .clk(clk), .rst_n(rst_n), .en_i(sh_en[7]), .data_i(in_data), .q_o(mlp1_threshold));

endmodule
